// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte protocol (receiver now, transmitter later).
package serial_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    // Clocks per oversample tick; never below one so the tick generator stays live.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned d;
        d = clk_freq / (baud * oversample);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// First-word-fall-through circular byte buffer; dout always shows the head entry.
module serial_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_next;

    // A push into a full buffer only lands when the head leaves in the same cycle.
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            valid <= (count_next != '0);
            full  <= (count_next == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/serial_rx.sv
// 8N1 LSB-first serial receiver feeding a small FWFT byte buffer.
// Define SERIAL_RX_PARITY_EN for 8E1 frames with a sticky parity_err output.
module serial_rx
    import serial_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    input  logic                        rd_en,
    input  logic                        clear_err,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
`ifdef SERIAL_RX_PARITY_EN
    output logic                        parity_err,
`endif
    output logic                        frame_err,
    output logic                        overrun
);

    localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned HALF   = OVERSAMPLE / 2;

    logic                 sync_meta;
    logic                 s;
    rx_state_e            state;
    rx_state_e            state_next;
    logic [DIV_W-1:0]     div_cnt;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;

    logic tick_c;
    logic mid_c;
    logic centre_c;
    logic restart_c;
    logic tick_clr_c;
    logic bit_clr_c;
    logic shift_en_c;
    logic push_c;
    logic frame_set_c;
    logic pop_c;
    logic overrun_set_c;
    logic full;

`ifdef SERIAL_RX_PARITY_EN
    logic parity_bad;
    logic parity_set_c;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            s         <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            s         <= sync_meta;
        end
    end

    assign tick_c   = (div_cnt == DIV_W'(DIV - 1));
    assign mid_c    = tick_c && (tick_cnt == TICK_W'(HALF - 1));
    assign centre_c = tick_c && (tick_cnt == TICK_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        restart_c   = 1'b0;
        tick_clr_c  = 1'b0;
        bit_clr_c   = 1'b0;
        shift_en_c  = 1'b0;
        push_c      = 1'b0;
        frame_set_c = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parity_set_c = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!s) begin
                    state_next = START;
                    restart_c  = 1'b1;
                end
            end
            START: begin
                // Half-bit recheck rejects short glitches on an idle line.
                if (mid_c) begin
                    if (!s) begin
                        state_next = DATA;
                        tick_clr_c = 1'b1;
                        bit_clr_c  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (centre_c) begin
                    shift_en_c = 1'b1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
                if (centre_c) begin
                    parity_set_c = ^{shift, s};
                    state_next   = STOP;
                end
`else
                state_next = IDLE;
`endif
            end
            STOP: begin
                if (centre_c) begin
                    if (s) begin
`ifdef SERIAL_RX_PARITY_EN
                        push_c = !parity_bad;
`else
                        push_c = 1'b1;
`endif
                        state_next = IDLE;
                    end else begin
                        frame_set_c = 1'b1;
                        state_next  = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold off through a break so it reports a single framing error.
                if (s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Tick generator and per-bit tick counter, realigned to each start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (restart_c) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
            if (tick_clr_c) begin
                tick_cnt <= '0;
            end else if (tick_c) begin
                tick_cnt <= (tick_cnt == TICK_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            if (bit_clr_c) begin
                bit_cnt <= '0;
            end else if (shift_en_c) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (shift_en_c) begin
                shift <= {s, shift[DATA_BITS-1:1]};
            end
        end
    end

    assign pop_c         = rd_en && rx_valid;
    assign overrun_set_c = push_c && full && !pop_c;

    // Sticky error flags; a fresh error beats a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set_c) begin
                frame_err <= 1'b1;
            end else if (clear_err) begin
                frame_err <= 1'b0;
            end
            if (overrun_set_c) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (restart_c) begin
                parity_bad <= 1'b0;
            end else if (parity_set_c) begin
                parity_bad <= 1'b1;
            end
            if (parity_set_c) begin
                parity_err <= 1'b1;
            end else if (clear_err) begin
                parity_err <= 1'b0;
            end
        end
    end
`endif

    serial_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .din   (shift),
        .dout  (rx_data),
        .valid (rx_valid),
        .full  (full),
        .count (rx_count)
    );

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Asynchronous serial (8N1, LSB first) receiver with a small first-word-fall-through byte buffer.
- Receiving end of the CPU's serial byte protocol: the same line format the CPU emits via its serial-out path.
- Gives the CPU (or a host loader) an input channel. Sits beside the accumulator and RAM; its head byte is presented for an accumulator or RAM load.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 4.
- FIFO_DEPTH, 4, buffered bytes; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- serial_in  in  1  raw line input; idle high; asynchronous to clk.
- rd_en  in  1  pops the head byte when rx_valid=1; ignored when rx_valid=0.
- clear_err  in  1  clears the sticky error flags.
- rx_data  out  8  head byte of the buffer; valid only while rx_valid=1.
- rx_valid  out  1  buffer non-empty.
- rx_count  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a byte was dropped because the buffer was full.

Behaviour:
- Reset: rx_data=0, rx_valid=0, rx_count=0, frame_err=0, overrun=0.
  - Synchronizer flops reset to 1. FSM goes to IDLE. Tick and bit counters are cleared.
  - Reset mid-frame abandons the frame. Reception restarts on the next falling edge after reset is released.
- Synchronizer: 2-flop synchronizer on serial_in. All logic uses the synchronized value `s`.
- Tick generator:
  - DIV = CLK_FREQ / (BAUD*OVERSAMPLE), integer floor, minimum 1.
  - Emits a 1-cycle tick every DIV clocks.
  - Free-running, but restarts at 0 on entry to START.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on s=0, go to START.
  - START: at tick OVERSAMPLE/2, if s=0 go to DATA with the sample counter cleared. If s=1, treat as a glitch and return to IDLE; nothing is pushed.
  - DATA: sample s every OVERSAMPLE ticks (bit centre). Shift into bit 7 of the shift register (LSB first). After 8 samples, go to STOP.
  - STOP: sample at bit centre.
    - s=1: push the byte and go to IDLE.
    - s=0: set frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until s=1, then go to IDLE. A break condition therefore produces exactly one frame_err.
- Buffer: FIFO_DEPTH-entry FWFT circular buffer.
  - rx_data always shows the head entry.
  - Push: rx_valid and rx_count update on the clock edge after the stop-bit sample.
  - Push when full without a simultaneous pop: byte dropped, overrun set, contents unchanged.
  - Push and pop in the same cycle when full: both happen; no overrun; count unchanged.
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: clear_err clears frame_err and overrun on the next edge. If a new error occurs in the same cycle as clear_err, the set wins.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- With the macro defined:
  - A PARITY state is inserted between DATA and STOP; it expects an even parity bit.
  - Adds output parity_err (1 bit, sticky, reset 0, cleared by clear_err).
  - On mismatch: set parity_err and discard the byte. Stop-bit handling is unchanged.
- Without the macro: frame is 8N1; no parity_err port exists.

Decomposition:
- Shared package serial_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE).
  - Constant DATA_BITS=8.
  - Function computing DIV from CLK_FREQ, BAUD, OVERSAMPLE. The same package serves the future transmitter.
- One sub-module: serial_rx_fifo (parameterised FWFT buffer with push, pop, full, count), instantiated once.

Test Plan:
- Bench setting for all scenarios: CLK_FREQ=16000000, BAUD=1000000, OVERSAMPLE=16 (DIV=1, one bit = 16 clocks).
- Single byte: send 0xA5 as 8N1 -> rx_valid rises 1 clock after the stop-bit centre sample; rx_data=0xA5; rx_count=1; rd_en=1 for one cycle -> rx_valid=0, rx_count=0.
- Fill/overrun: send 0x01..0x05 with no reads -> rx_count=4 and overrun=1. Reading 4 times returns 0x01, 0x02, 0x03, 0x04; 0x05 is absent. clear_err -> overrun=0.
- Push and pop at full: buffer full (4 bytes); assert rd_en on the exact cycle byte 0x55 is pushed -> overrun stays 0, rx_count stays 4, last byte read out is 0x55.
- Framing error and glitch rejection:
  - Send 0x3C with the stop bit low, then hold the line low for 40 bit times, then idle -> frame_err=1 exactly once, nothing buffered; the next valid 0x7E is received correctly.
  - A 4-clock low glitch on an idle line -> no byte, no error.
- Reset mid-frame: assert reset during bit 3 of 0xFF -> all outputs 0 immediately (asynchronous); after release, a following 0x42 is received as 0x42.
- With SERIAL_RX_PARITY_EN: send 0x07 with parity bit 1 -> byte buffered. Send 0x07 with parity bit 0 -> parity_err=1, nothing buffered.
